// File: rtl/apb_master_bridge_if.sv
// Requester-side handshake and two-slave APB bus of the bridge.
// The master modport is the bridge; the slave modport is whatever sits
// on the other side (requester plus both APB slaves).
interface apb_master_bridge_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic        PSEL1;
   logic        PSEL2;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA1;
   logic [31:0] PRDATA2;
   logic        PREADY1;
   logic        PREADY2;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  PRDATA1, PRDATA2, PREADY1, PREADY2,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output PRDATA1, PRDATA2, PREADY1, PREADY2,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-request APB master bridge driving two slaves.
// One transfer at a time: IDLE accepts, SETUP selects, ACCESS waits for the
// selected slave's PREADY or gives up after TIMEOUT low cycles. Every bus
// and response output comes straight from a flop.
module apb_master_bridge #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned SEL_BIT = 8
) (
   input  logic                PCLK,
   input  logic                PRESETn,
   apb_master_bridge_if.master bus
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;

   logic          psel1_q, psel1_d;
   logic          psel2_q, psel2_d;
   logic          penable_q, penable_d;
   logic          pwrite_q, pwrite_d;
   logic [31:0]   paddr_q, paddr_d;
   logic [31:0]   pwdata_q, pwdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          sel2;
   logic          sel_ready;
   logic [31:0]   sel_rdata;
   logic          timeout_hit;

   // PADDR is frozen for the whole transfer, so its select bit picks the slave
   assign sel2        = paddr_q[SEL_BIT];
   assign sel_ready   = sel2 ? bus.PREADY2 : bus.PREADY1;
   assign sel_rdata   = sel2 ? bus.PRDATA2 : bus.PRDATA1;
   // This low-ready cycle is the TIMEOUT-th consecutive one
   assign timeout_hit = (wait_q == CW'(TIMEOUT - 1));

   assign bus.req_ready = (state_q == IDLE);
   assign bus.PSEL1     = psel1_q;
   assign bus.PSEL2     = psel2_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rdata_q;

   // State and all registered outputs; reset drops the bus immediately
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         psel1_q     <= 1'b0;
         psel2_q     <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         psel1_q     <= psel1_d;
         psel2_q     <= psel2_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
      end
   end

   // Next state plus next value of every registered output
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      psel1_d     = psel1_q;
      psel2_d     = psel2_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rdata_d     = rdata_q;

      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d   = SETUP;
               wait_d    = '0;
               pwrite_d  = bus.req_write;
               paddr_d   = bus.req_addr;
               pwdata_d  = bus.req_wdata;
               psel1_d   = ~bus.req_addr[SEL_BIT];
               psel2_d   = bus.req_addr[SEL_BIT];
               penable_d = 1'b0;
            end
         end

         SETUP: begin
            state_d   = ACCESS;
            wait_d    = '0;
            penable_d = 1'b1;
         end

         ACCESS: begin
            // Completion is tested first so a late PREADY beats the abort
            if (sel_ready) begin
               state_d     = IDLE;
               psel1_d     = 1'b0;
               psel2_d     = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rdata_d     = pwrite_q ? '0 : sel_rdata;
            end else if (timeout_hit) begin
               state_d     = IDLE;
               wait_d      = wait_q + CW'(1);
               psel1_d     = 1'b0;
               psel2_d     = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rdata_d     = '0;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised bench for apb_master_bridge with a transaction-level model.
// Each request carries its own slave behaviour (wait states, or a hang that
// forces a timeout); the model derives the expected bus and response
// timeline from the cycle offset since acceptance.
module tb_apb_master_bridge;
   localparam int unsigned TO    = 4;
   localparam int unsigned SB    = 8;
   localparam int unsigned LIMIT = 6000;
   localparam int unsigned NDIR  = 6;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int unsigned w;     // PREADY-low cycles before ready; >= TO means hang
      int unsigned gap;   // idle cycles before req_valid is raised
   } txn_t;

   logic PCLK = 1'b0;
   logic PRESETn = 1'b0;
   always #5 PCLK = ~PCLK;

   apb_master_bridge_if bus ();

   apb_master_bridge #(.TIMEOUT(TO), .SEL_BIT(SB)) dut (
      .PCLK   (PCLK),
      .PRESETn(PRESETn),
      .bus    (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   txn_t        q[$];
   txn_t        pend, cur;
   bit          have_pend = 0;
   int unsigned gapc = 0;

   bit          busy = 0, pulse = 0, perr = 0;
   int unsigned k = 0, endk = 0, cur_idx = 0;
   logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
   logic        e_write = 1'b0;
   logic        e_ready, e_psel1, e_psel2, e_pen;

   int unsigned cyc = 0, acc_idx = 0, rsp_idx = 0;
   int unsigned acc_cyc[1024];
   int unsigned rsp_cyc[1024];
   logic [31:0] rsp_rd[1024];
   logic        rsp_er[1024];

   initial begin
      txn_t t;
      bit   rdy, unsel;

      bus.req_valid = 1'b0; bus.req_write = 1'b0;
      bus.req_addr  = '0;   bus.req_wdata = '0;
      bus.PREADY1   = 1'b0; bus.PREADY2   = 1'b0;
      bus.PRDATA1   = '0;   bus.PRDATA2   = '0;

      // Directed: write zero-wait, read slave2 two waits, timeout,
      // back-to-back pair, PREADY on the last permitted cycle
      t = '{write:1'b1, addr:32'h0000_0004, wdata:32'hDEAD_BEEF, rdata:32'h0,         w:0,      gap:1}; q.push_back(t);
      t = '{write:1'b0, addr:32'h0000_0105, wdata:32'h0,         rdata:32'h1234_5678, w:2,      gap:2}; q.push_back(t);
      t = '{write:1'b0, addr:32'h0000_0010, wdata:32'h0,         rdata:32'h5555_AAAA, w:TO,     gap:1}; q.push_back(t);
      t = '{write:1'b1, addr:32'h0000_0020, wdata:32'h0BAD_F00D, rdata:32'h0,         w:0,      gap:1}; q.push_back(t);
      t = '{write:1'b1, addr:32'h0000_0124, wdata:32'h1357_9BDF, rdata:32'h0,         w:0,      gap:0}; q.push_back(t);
      t = '{write:1'b0, addr:32'h0000_0030, wdata:32'h0,         rdata:32'hCAFE_F00D, w:TO - 1, gap:2}; q.push_back(t);

      for (int i = 0; i < 200; i++) begin
         t.write = 1'($urandom_range(0, 1));
         t.addr  = $urandom;
         t.addr[SB] = 1'($urandom_range(0, 1));
         t.wdata = $urandom;
         t.rdata = $urandom;
         t.w     = ($urandom_range(0, 9) < 7) ? $urandom_range(0, TO - 1) : TO + $urandom_range(0, 2);
         t.gap   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         q.push_back(t);
      end

      // Reset state
      repeat (3) @(negedge PCLK);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_PSEL1",     32'(bus.PSEL1),     32'd0);
      chk("rst_PSEL2",     32'(bus.PSEL2),     32'd0);
      chk("rst_PENABLE",   32'(bus.PENABLE),   32'd0);
      chk("rst_PWRITE",    32'(bus.PWRITE),    32'd0);
      chk("rst_PADDR",     bus.PADDR,          32'd0);
      chk("rst_PWDATA",    bus.PWDATA,         32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
      PRESETn = 1'b1;

      while (cyc < LIMIT && (q.size() != 0 || have_pend || busy || pulse)) begin
         // Expected outputs for the current cycle
         if (busy) begin
            e_ready = 1'b0;
            e_psel1 = ~cur.addr[SB];
            e_psel2 = cur.addr[SB];
            e_pen   = (k >= 2);
         end else begin
            e_ready = 1'b1;
            e_psel1 = 1'b0;
            e_psel2 = 1'b0;
            e_pen   = 1'b0;
         end
         chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
         chk("PSEL1",     32'(bus.PSEL1),     32'(e_psel1));
         chk("PSEL2",     32'(bus.PSEL2),     32'(e_psel2));
         chk("PENABLE",   32'(bus.PENABLE),   32'(e_pen));
         chk("PWRITE",    32'(bus.PWRITE),    32'(e_write));
         chk("PADDR",     bus.PADDR,          e_addr);
         chk("PWDATA",    bus.PWDATA,         e_wdata);
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(pulse));
         chk("rsp_err",   32'(bus.rsp_err),   32'(pulse && perr));
         chk("rsp_rdata", bus.rsp_rdata,      e_rdata);
         if (bus.rsp_valid === 1'b1 && rsp_idx < 1024) begin
            rsp_cyc[rsp_idx] = cyc;
            rsp_rd[rsp_idx]  = bus.rsp_rdata;
            rsp_er[rsp_idx]  = bus.rsp_err;
            rsp_idx++;
         end

         // Slaves: random everywhere except the selected one during ACCESS
         bus.PRDATA1 = $urandom;
         bus.PRDATA2 = $urandom;
         bus.PREADY1 = 1'($urandom_range(0, 1));
         bus.PREADY2 = 1'($urandom_range(0, 1));
         if (busy && k >= 2) begin
            rdy   = (cur.w < TO) && (k - 2 >= cur.w);
            unsel = (cur_idx < NDIR) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cur.addr[SB]) begin
               bus.PREADY2 = rdy;
               bus.PREADY1 = unsel;
               if (rdy) bus.PRDATA2 = cur.rdata;
            end else begin
               bus.PREADY1 = rdy;
               bus.PREADY2 = unsel;
               if (rdy) bus.PRDATA1 = cur.rdata;
            end
         end

         // Requester: hold a pending request until it is taken
         if (!have_pend && q.size() != 0) begin
            pend      = q.pop_front();
            have_pend = 1;
            gapc      = pend.gap;
         end
         if (have_pend && gapc == 0) begin
            bus.req_valid = 1'b1;
            bus.req_write = pend.write;
            bus.req_addr  = pend.addr;
            bus.req_wdata = pend.wdata;
         end else begin
            if (have_pend) gapc--;
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
         end

         // Model advances to the next cycle
         pulse = 0;
         if (busy) begin
            k++;
            if (k == endk) begin
               busy    = 0;
               pulse   = 1;
               perr    = (cur.w >= TO);
               e_rdata = (perr || cur.write) ? 32'h0 : cur.rdata;
            end
         end else if (bus.req_valid) begin
            cur       = pend;
            have_pend = 0;
            busy      = 1;
            k         = 1;
            endk      = (cur.w < TO) ? 3 + cur.w : 2 + TO;
            e_addr    = cur.addr;
            e_wdata   = cur.wdata;
            e_write   = cur.write;
            cur_idx   = acc_idx;
            if (acc_idx < 1024) acc_cyc[acc_idx] = cyc;
            acc_idx++;
         end

         @(negedge PCLK);
         cyc++;
      end
      chk("drain_in_budget", 32'(cyc < LIMIT), 32'd1);
      chk("rsp_count",       rsp_idx,          acc_idx);

      // Hand-computed expectations for the directed requests
      chk("lat_write_0wait",  rsp_cyc[0] - acc_cyc[0], 32'd3);
      chk("rdata_write",      rsp_rd[0],               32'h0);
      chk("err_write",        32'(rsp_er[0]),          32'd0);
      chk("lat_read_2wait",   rsp_cyc[1] - acc_cyc[1], 32'd5);
      chk("rdata_read_s2",    rsp_rd[1],               32'h1234_5678);
      chk("lat_timeout",      rsp_cyc[2] - acc_cyc[2], 32'd6);
      chk("err_timeout",      32'(rsp_er[2]),          32'd1);
      chk("rdata_timeout",    rsp_rd[2],               32'h0);
      chk("lat_b2b_first",    rsp_cyc[3] - acc_cyc[3], 32'd3);
      chk("b2b_accept_cycle", acc_cyc[4],              rsp_cyc[3]);
      chk("lat_ready_at_lim", rsp_cyc[5] - acc_cyc[5], 32'd6);
      chk("err_ready_at_lim", 32'(rsp_er[5]),          32'd0);
      chk("rdata_ready_lim",  rsp_rd[5],               32'hCAFE_F00D);

      // Reset during ACCESS
      bus.PREADY1   = 1'b0;
      bus.PREADY2   = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h0000_0200;
      @(negedge PCLK);
      bus.req_valid = 1'b0;
      for (int i = 0; i < 8 && bus.PENABLE !== 1'b1; i++) @(negedge PCLK);
      chk("rst_mid_in_access", 32'(bus.PENABLE), 32'd1);
      #2 PRESETn = 1'b0;
      #1;
      chk("rst_mid_PSEL1",     32'(bus.PSEL1),     32'd0);
      chk("rst_mid_PSEL2",     32'(bus.PSEL2),     32'd0);
      chk("rst_mid_PENABLE",   32'(bus.PENABLE),   32'd0);
      chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      repeat (2) begin
         @(negedge PCLK);
         chk("rst_hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      PRESETn = 1'b1;
      chk("rst_rel_req_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) begin
         @(negedge PCLK);
         chk("rst_rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_rel_PSEL2",     32'(bus.PSEL2),     32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
